sap_controller_sequencer: RTL and testbench
===========================================

// Module: sap_controller_sequencer
// PURPOSE
//  Control sequencer for the 8-bit CPU; sits directly upstream of the program counter.
//  - A one-hot ring counter steps T1..T6.
//  - Each T-state, with the IR opcode and ALU flags, is decoded into the control word.
//  - The control word drives the PC (cp/ep/lp/clr_n), MAR, RAM, IR, A/B regs, ALU and OUT reg.
//  - Supports HLT (sticky stop) and optional early return to T1 after the last active state.
// PARAMETERS
//  OP_W       4  opcode width (upper nibble of the instruction register)
//  SKIP_IDLE  0  0: every instruction takes 6 T-states; 1: return to T1 after the opcode's last active T-state
// PORTS
//  clk       in   1    system clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  opcode    in   OP_W IR upper nibble; stable from T4 through the end of the instruction
//  flag_z    in   1    ALU zero flag
//  flag_c    in   1    ALU carry flag
//  t_state   out  6    one-hot ring state, bit0=T1 .. bit5=T6; all zero in RESET/HALT
//  pc_clr_n  out  1    synchronous clear to the PC, active low
//  cp        out  1    PC count enable
//  ep        out  1    PC output enable onto bus
//  lp        out  1    PC load from bus (jump)
//  lm        out  1    MAR load
//  ce        out  1    RAM output enable
//  li        out  1    IR load
//  ei        out  1    IR operand (low nibble) enable
//  la        out  1    A reg load
//  ea        out  1    A reg enable
//  lb        out  1    B reg load
//  su        out  1    ALU subtract select
//  eu        out  1    ALU output enable
//  lo        out  1    OUT reg load
//  hlt       out  1    halted indicator, sticky
// BEHAVIOUR
//  - States: RESET, T1..T6, HALT.
//    - rst_n low -> RESET asynchronously.
//    - RESET: all control outputs 0, pc_clr_n=0, t_state=0.
//    - First rising edge after rst_n high: RESET -> T1. This edge clears the PC.
//    - Ring: T1->T2->..->T6->T1, one state per clock.
//  - Control outputs are decoded combinationally from the registered state and the opcode/flags.
//    - They are valid for the whole T-state cycle and are consumed on the edge that ends it.
//  - pc_clr_n = 1 in every state except RESET.
//  - Fetch, identical for all opcodes:
//    - T1: ep, lm
//    - T2: cp
//    - T3: ce, li
//  - Execute (T4/T5/T6):
//    - LDA 0000: T4 ei,lm | T5 ce,la | T6 -
//    - ADD 0001: T4 ei,lm | T5 ce,lb | T6 eu,la
//    - SUB 0010: T4 ei,lm | T5 ce,lb | T6 eu,la,su
//    - JMP 0011: T4 ei,lp | T5 - | T6 -
//    - JZ  0100: T4 ei,lp only if flag_z=1 | T5 - | T6 -
//    - JC  0101: T4 ei,lp only if flag_c=1 | T5 - | T6 -
//    - OUT 1110: T4 ea,lo | T5 - | T6 -
//    - HLT 1111: T4 enters HALT (see below)
//    - any other opcode: NOP, no execute signals
//  - Flags are sampled combinationally during T4 only; changes in T5/T6 have no effect.
//  - Mutual exclusion: at most one bus driver (ep, ce, ei, ea, eu) high in any cycle. The bench asserts this every cycle.
//  - HLT:
//    - In T4 with opcode 1111, hlt=1 combinationally and all other control outputs are 0.
//    - The next edge enters HALT: t_state=0, all control outputs 0, hlt=1.
//    - Only rst_n low exits HALT.
//  - SKIP_IDLE=1: the state after the last active state is T1.
//    - LDA: T5->T1
//    - JMP/JZ/JC/OUT/NOP: T4->T1
//    - ADD/SUB: unchanged, full 6 states
//  - Reset mid-instruction: immediate async return to RESET. Outputs drop in the same cycle. No partial control word persists.
//  - The opcode is never latched internally. A change during T4..T6 changes the decode; the IR guarantees stability.
// TESTING
//  1. Reset release, opcode=0000, 7 clocks:
//     - pc_clr_n=0 until the first edge
//     - t_state = 000001, 000010, .., 100000, 000001
//     - T1 ep=lm=1, T2 cp=1, T3 ce=li=1, T5 ce=la=1
//  2. opcode=0010 (SUB):
//     - T6 eu=la=su=1, every other output 0
//     - su is 0 in T1..T5
//  3. JZ with flag_z=1 in T4 -> ei=lp=1 in T4.
//     Repeat with flag_z=0 -> lp=0. flag_z toggled in T5 -> no change.
//  4. opcode=1111 at T4:
//     - hlt=1 in T4, then t_state=0 and hlt held 20 cycles
//     - rst_n pulse -> RESET, then T1
//  5. SKIP_IDLE=1, opcode=0011:
//     - sequence T1,T2,T3,T4,T1
//     - ADD still runs T1..T6
//  6. rst_n low asynchronously mid-T5 of ADD:
//     - all outputs 0 before the next edge, pc_clr_n=0
//     - recovery on release goes to T1

Source files
------------

// File: rtl/sap_controller_sequencer_if.sv
// Control-sequencer bus: IR opcode and ALU flags in, ring state and control word out.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface sap_controller_sequencer_if #(
  parameter int OP_W = 4
);
  logic [OP_W-1:0] opcode;
  logic            flag_z;
  logic            flag_c;
  logic [5:0]      t_state;
  logic            pc_clr_n;
  logic            cp;
  logic            ep;
  logic            lp;
  logic            lm;
  logic            ce;
  logic            li;
  logic            ei;
  logic            la;
  logic            ea;
  logic            lb;
  logic            su;
  logic            eu;
  logic            lo;
  logic            hlt;

  modport master (
    input  opcode, flag_z, flag_c,
    output t_state, pc_clr_n, cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt
  );

  modport slave (
    output opcode, flag_z, flag_c,
    input  t_state, pc_clr_n, cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt
  );
endinterface

// File: rtl/sap_controller_sequencer.sv
// SAP-style control sequencer: T1..T6 ring plus RESET/HALT, decoding the
// current T-state, opcode and ALU flags into the datapath control word.
module sap_controller_sequencer #(
  parameter int OP_W      = 4,
  parameter int SKIP_IDLE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sap_controller_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_RESET,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'b0101);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

  localparam bit SKIP = (SKIP_IDLE != 0);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_next;
  end

  // Opcode and flags are never latched: the IR holds them stable, so decode is purely combinational.
  always_comb begin
    state_next   = state;
    bus.t_state  = 6'b000000;
    bus.pc_clr_n = 1'b1;
    bus.cp       = 1'b0;
    bus.ep       = 1'b0;
    bus.lp       = 1'b0;
    bus.lm       = 1'b0;
    bus.ce       = 1'b0;
    bus.li       = 1'b0;
    bus.ei       = 1'b0;
    bus.la       = 1'b0;
    bus.ea       = 1'b0;
    bus.lb       = 1'b0;
    bus.su       = 1'b0;
    bus.eu       = 1'b0;
    bus.lo       = 1'b0;
    bus.hlt      = 1'b0;

    unique case (state)
      S_RESET: begin
        bus.pc_clr_n = 1'b0;
        state_next   = S_T1;
      end
      S_T1: begin
        bus.t_state = 6'b000001;
        bus.ep      = 1'b1;
        bus.lm      = 1'b1;
        state_next  = S_T2;
      end
      S_T2: begin
        bus.t_state = 6'b000010;
        bus.cp      = 1'b1;
        state_next  = S_T3;
      end
      S_T3: begin
        bus.t_state = 6'b000100;
        bus.ce      = 1'b1;
        bus.li      = 1'b1;
        state_next  = S_T4;
      end
      S_T4: begin
        bus.t_state = 6'b001000;
        state_next  = SKIP ? S_T1 : S_T5;
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            bus.ei     = 1'b1;
            bus.lm     = 1'b1;
            state_next = S_T5;
          end
          OP_JMP: begin
            bus.ei = 1'b1;
            bus.lp = 1'b1;
          end
          OP_JZ: begin
            bus.ei = bus.flag_z;
            bus.lp = bus.flag_z;
          end
          OP_JC: begin
            bus.ei = bus.flag_c;
            bus.lp = bus.flag_c;
          end
          OP_OUT: begin
            bus.ea = 1'b1;
            bus.lo = 1'b1;
          end
          OP_HLT: begin
            bus.hlt    = 1'b1;
            state_next = S_HALT;
          end
          default: ;
        endcase
      end
      S_T5: begin
        bus.t_state = 6'b010000;
        state_next  = S_T6;
        case (bus.opcode)
          OP_LDA: begin
            bus.ce     = 1'b1;
            bus.la     = 1'b1;
            state_next = SKIP ? S_T1 : S_T6;
          end
          OP_ADD, OP_SUB: begin
            bus.ce = 1'b1;
            bus.lb = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        bus.t_state = 6'b100000;
        state_next  = S_T1;
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          bus.eu = 1'b1;
          bus.la = 1'b1;
          bus.su = (bus.opcode == OP_SUB);
        end
      end
      S_HALT: begin
        bus.hlt    = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Self-checking bench for sap_controller_sequencer: one instance per SKIP_IDLE
// setting, with a scoreboard of expected control words built from the opcode table.
module tb_sap_controller_sequencer;

  typedef struct packed {
    logic [5:0] t;
    logic clr_n, cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt;
  } word_t;

  typedef struct {
    int    sel;
    word_t exp;
    string tag;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_compared   = 0;
  int n_mismatched = 0;

  sb_entry_t sb_q[$];

  int         step_v[2];
  logic [3:0] op_v[2];
  logic       fz_v[2];
  logic       fc_v[2];
  bit         skip_v[2] = '{0, 1};

  sap_controller_sequencer_if #(.OP_W(4)) if0 ();
  sap_controller_sequencer_if #(.OP_W(4)) if1 ();

  sap_controller_sequencer #(.OP_W(4), .SKIP_IDLE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  sap_controller_sequencer #(.OP_W(4), .SKIP_IDLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, got, want);
    end
  endtask

  // Expected control word straight from the opcode table; step 0=RESET, 1..6=T1..T6, 7=HALT.
  function automatic word_t model(int step, logic [3:0] op, logic fz, logic fc);
    word_t w;
    w       = '0;
    w.clr_n = (step != 0);
    case (step)
      1: begin w.t = 6'b000001; w.ep = 1; w.lm = 1; end
      2: begin w.t = 6'b000010; w.cp = 1; end
      3: begin w.t = 6'b000100; w.ce = 1; w.li = 1; end
      4: begin
        w.t = 6'b001000;
        case (op)
          4'h0, 4'h1, 4'h2: begin w.ei = 1; w.lm = 1; end
          4'h3: begin w.ei = 1; w.lp = 1; end
          4'h4: if (fz) begin w.ei = 1; w.lp = 1; end
          4'h5: if (fc) begin w.ei = 1; w.lp = 1; end
          4'hE: begin w.ea = 1; w.lo = 1; end
          4'hF: w.hlt = 1;
          default: ;
        endcase
      end
      5: begin
        w.t = 6'b010000;
        if (op == 4'h0) begin w.ce = 1; w.la = 1; end
        if (op == 4'h1 || op == 4'h2) begin w.ce = 1; w.lb = 1; end
      end
      6: begin
        w.t = 6'b100000;
        if (op == 4'h1) begin w.eu = 1; w.la = 1; end
        if (op == 4'h2) begin w.eu = 1; w.la = 1; w.su = 1; end
      end
      7: w.hlt = 1;
      default: ;
    endcase
    return w;
  endfunction

  function automatic int next_step(int step, logic [3:0] op, bit skip);
    case (step)
      0, 1, 2, 3: return step + 1;
      4: begin
        if (op == 4'hF) return 7;
        if (skip && !(op == 4'h0 || op == 4'h1 || op == 4'h2)) return 1;
        return 5;
      end
      5: return (skip && op == 4'h0) ? 1 : 6;
      6: return 1;
      default: return 7;
    endcase
  endfunction

  function automatic word_t obs(int sel);
    word_t w;
    if (sel == 0)
      w = {if0.t_state, if0.pc_clr_n, if0.cp, if0.ep, if0.lp, if0.lm, if0.ce, if0.li,
           if0.ei, if0.la, if0.ea, if0.lb, if0.su, if0.eu, if0.lo, if0.hlt};
    else
      w = {if1.t_state, if1.pc_clr_n, if1.cp, if1.ep, if1.lp, if1.lm, if1.ce, if1.li,
           if1.ei, if1.la, if1.ea, if1.lb, if1.su, if1.eu, if1.lo, if1.hlt};
    return w;
  endfunction

  task automatic applyStimulus(input int sel, input logic [3:0] op, input logic fz,
                               input logic fc, input string tag);
    sb_entry_t e;
    op_v[sel] = op;
    fz_v[sel] = fz;
    fc_v[sel] = fc;
    if (sel == 0) begin
      if0.opcode = op; if0.flag_z = fz; if0.flag_c = fc;
    end else begin
      if1.opcode = op; if1.flag_z = fz; if1.flag_c = fc;
    end
    e.sel = sel;
    e.exp = model(step_v[sel], op, fz, fc);
    e.tag = $sformatf("%s_d%0d_s%0d", tag, sel, step_v[sel]);
    sb_q.push_back(e);
  endtask

  task automatic popCheck();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      checkOutput(e.tag, 32'(obs(e.sel)), 32'(e.exp));
    end
  endtask

  task automatic step_cycle(input int sel, input logic [3:0] op, input logic fz,
                            input logic fc, input string tag);
    applyStimulus(sel, op, fz, fc, tag);
    #1;
    popCheck();
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++)
      if (rst_n) step_v[i] = next_step(step_v[i], op_v[i], skip_v[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    step_v[0] = 0;
    step_v[1] = 0;
  endtask

  task automatic align_t1(input int sel);
    for (int g = 0; g < 10 && step_v[sel] != 1; g++) begin
      step_cycle(sel, op_v[sel], 1'b0, 1'b0, "align");
      tick();
    end
  endtask

  // Runs one instruction from T1; f4 drives both flags in T4, flate in every other state.
  task automatic runInstr(input int sel, input logic [3:0] op, input logic f4,
                          input logic flate, input int maxc, input string tag);
    logic f;
    int   cnt;
    align_t1(sel);
    cnt = 0;
    do begin
      f = (step_v[sel] == 4) ? f4 : flate;
      step_cycle(sel, op, f, f, tag);
      tick();
      cnt++;
    end while (step_v[sel] != 1 && cnt < maxc);
  endtask

  // Bus-driver exclusivity on both instances, every cycle.
  always @(negedge clk) begin
    checkOutput("excl_d0", 32'($onehot0({if0.ep, if0.ce, if0.ei, if0.ea, if0.eu})), 32'd1);
    checkOutput("excl_d1", 32'($onehot0({if1.ep, if1.ce, if1.ei, if1.ea, if1.eu})), 32'd1);
  end

  initial begin
    enter_reset();
    op_v = '{4'h0, 4'h0};
    step_cycle(0, 4'h0, 1'b0, 1'b0, "rst");
    step_cycle(1, 4'h0, 1'b0, 1'b0, "rst");
    tick();
    tick();
    #2 rst_n = 1'b1;
    step_cycle(0, 4'h0, 1'b0, 1'b0, "rel");
    tick();

    // LDA through a full ring and back to T1, both instances side by side.
    for (int i = 0; i < 7; i++) begin
      step_cycle(0, 4'h0, 1'b0, 1'b0, "lda");
      step_cycle(1, 4'h0, 1'b0, 1'b0, "lda_skip");
      tick();
    end

    runInstr(0, 4'h2, 1'b0, 1'b0, 8, "sub");
    runInstr(0, 4'h1, 1'b1, 1'b1, 8, "add");
    runInstr(0, 4'h4, 1'b1, 1'b0, 8, "jz1");
    runInstr(0, 4'h4, 1'b0, 1'b1, 8, "jz0");
    runInstr(0, 4'h5, 1'b1, 1'b0, 8, "jc1");
    runInstr(0, 4'h5, 1'b0, 1'b1, 8, "jc0");
    runInstr(0, 4'hE, 1'b0, 1'b0, 8, "out");
    runInstr(0, 4'h7, 1'b0, 1'b0, 8, "nop");

    runInstr(0, 4'hF, 1'b0, 1'b0, 24, "hlt");
    checkOutput("halt_sticky_d0", 32'(if0.hlt), 32'd1);
    enter_reset();
    step_cycle(0, op_v[0], 1'b0, 1'b0, "hlt_rst");
    step_cycle(1, op_v[1], 1'b0, 1'b0, "hlt_rst");
    #1 rst_n = 1'b1;
    tick();
    step_cycle(0, 4'h0, 1'b0, 1'b0, "hlt_rec");

    runInstr(1, 4'h3, 1'b0, 1'b0, 8, "jmp_skip");
    runInstr(1, 4'h1, 1'b0, 1'b0, 8, "add_skip");
    runInstr(1, 4'h0, 1'b0, 1'b0, 8, "lda_skip");
    runInstr(1, 4'hE, 1'b0, 1'b0, 8, "out_skip");
    runInstr(1, 4'h4, 1'b1, 1'b0, 8, "jz_skip");
    runInstr(1, 4'h9, 1'b0, 1'b0, 8, "nop_skip");
    runInstr(1, 4'hF, 1'b0, 1'b0, 6, "hlt_skip");

    // ADD interrupted by reset in the middle of T5.
    align_t1(0);
    for (int i = 0; i < 4; i++) begin
      step_cycle(0, 4'h1, 1'b0, 1'b0, "add_pre");
      tick();
    end
    step_cycle(0, 4'h1, 1'b0, 1'b0, "add_t5");
    #1 enter_reset();
    step_cycle(0, 4'h1, 1'b0, 1'b0, "midrst");
    step_cycle(1, op_v[1], 1'b0, 1'b0, "midrst");
    #1 rst_n = 1'b1;
    step_cycle(0, 4'h1, 1'b0, 1'b0, "midrst_rel");
    tick();
    step_cycle(0, 4'h1, 1'b0, 1'b0, "midrst_rec");
    step_cycle(1, op_v[1], 1'b0, 1'b0, "midrst_rec");

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
